if_stage: RTL and testbench

Instruction-fetch stage of the MIPS pipeline: owns the program counter, issues word fetches to instruction memory over a req/ready handshake, and drives the PC+4 and instruction inputs of the IF/ID pipeline register. It absorbs memory wait states by presenting a NOP bubble and applies branch redirects from EXE. It also discards a fetch still in flight when a redirect arrives, and holds a completed fetch while the pipeline is frozen.

---
 rtl/if_pkg.sv | 33 +++
 rtl/if_stage_if.sv | 32 +++
 rtl/if_stage.sv | 165 ++++++++++++++++
 tb/tb_if_stage.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_pkg
// Description : Shared types and constants for the MIPS instruction-fetch
//               stage: FSM state encoding, the NOP word, the default reset PC
//               and a PC increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

    // Fetch FSM states
    //   S_FETCH   : request to pc outstanding
    //   S_DISCARD : in-flight request must be dropped, then fetch pend
    //   S_HOLD    : completed word parked in hold until freeze falls
    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DISCARD = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Clears the byte-offset bits of a redirect target.
    localparam logic [31:0] ADDR_ALIGN_MASK  = 32'hFFFF_FFFC;

    // Sequential next word address; wraps naturally at 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_if
// Description : Instruction-memory request bus between the fetch stage and
//               instruction memory.
//   imem_req   : fetch request outstanding        (master -> slave)
//   imem_addr  : word-aligned byte address        (master -> slave)
//   imem_ready : one-cycle completion strobe      (slave -> master)
//   imem_rdata : instruction word, valid w/ ready (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : MIPS instruction-fetch stage. Owns the program counter,
//               fetches words over a req/ready handshake, inserts NOP bubbles
//               on memory wait states, applies EXE branch redirects (dropping
//               a fetch still in flight) and parks a completed word while the
//               pipeline is frozen.
// Ports       :
//   clk          in   pipeline clock, rising edge
//   rst          in   asynchronous active-high reset
//   freeze       in   hazard stall (also freezes IF/ID)
//   Branch_taken in   redirect request (same cycle as IF/ID flush)
//   Branch_Addr  in   redirect target, bits [1:0] ignored
//   imem         bus  if_stage_if.master instruction-memory port
//   PC           out  fetched address + 4, to IF/ID
//   Instruction  out  fetched word or NOP, to IF/ID
//   Stall_Count  out  cycles with no instruction delivered, saturating
//                     (present only when IF_STALL_CNT_EN is defined)
// Config      : `define IF_STALL_CNT_EN to add the stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        freeze,
    input  wire logic        Branch_taken,
    input  wire logic [31:0] Branch_Addr,
    if_stage_if.master       imem,
    output logic      [31:0] PC,
    output logic      [31:0] Instruction
`ifdef IF_STALL_CNT_EN
    ,
    output logic      [31:0] Stall_Count
`endif
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_pend;
    logic [31:0] w_pend_nxt;
    logic [31:0] r_hold;
    logic [31:0] w_hold_nxt;

    logic [31:0] w_target;
    logic [31:0] w_pc_inc;
    logic        w_fetch_ok;

    assign w_target = Branch_Addr & ADDR_ALIGN_MASK;
    assign w_pc_inc = pc_plus4(r_pc);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_pend  <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_pend  <= w_pend_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; Branch_taken outranks freeze in every state.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend;
        w_hold_nxt  = r_hold;

        case (r_state)
            S_FETCH: begin
                if (Branch_taken) begin
                    if (imem.imem_ready) begin
                        // Completed word is flushed by IF/ID; refetch at target.
                        w_pc_nxt = w_target;
                    end else begin
                        // Request already issued to memory cannot be cancelled,
                        // so remember the target and wait for it to drain.
                        w_pend_nxt  = w_target;
                        w_state_nxt = S_DISCARD;
                    end
                end else if (imem.imem_ready) begin
                    if (freeze) begin
                        w_hold_nxt  = imem.imem_rdata;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
            end

            S_DISCARD: begin
                if (Branch_taken) begin
                    w_pend_nxt = w_target;
                end
                if (imem.imem_ready) begin
                    w_pc_nxt    = Branch_taken ? w_target : r_pend;
                    w_state_nxt = S_FETCH;
                end
            end

            S_HOLD: begin
                if (Branch_taken) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_FETCH;
                end else if (!freeze) begin
                    // Held word is consumed by IF/ID on this edge.
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = S_FETCH;
                end
            end

            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // No request while a word is parked: memory would return a word we
    // have nowhere to store.
    assign imem.imem_req  = ~rst & (r_state != S_HOLD);
    assign imem.imem_addr = r_pc;

    assign w_fetch_ok  = ((r_state == S_FETCH) & imem.imem_ready) | (r_state == S_HOLD);
    assign Instruction = w_fetch_ok ? ((r_state == S_HOLD) ? r_hold : imem.imem_rdata) : NOP;
    assign PC          = w_pc_inc;

`ifdef IF_STALL_CNT_EN
    // ------------------------------------------------------------------
    // Saturating bubble counter
    // ------------------------------------------------------------------
    localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

    logic [31:0] r_stall_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (!w_fetch_ok && (r_stall_count != STALL_MAX)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign Stall_Count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Directed self-checking bench for if_stage. Memory returns the
//               bitwise inverse of the address as data so a fetched word at
//               address 0 is distinguishable from a NOP. imem_ready is
//               combinational from imem_req gated by a bench-controlled enable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        Branch_taken;
    logic [31:0] Branch_Addr;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        ready_en;
`ifdef IF_STALL_CNT_EN
    logic [31:0] Stall_Count;
`endif

    int n_tests;
    int n_fail;

    if_stage_if imem_bus();

    assign imem_bus.imem_ready = imem_bus.imem_req & ready_en;
    assign imem_bus.imem_rdata = ~imem_bus.imem_addr;

    if_stage #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .Branch_taken (Branch_taken),
        .Branch_Addr  (Branch_Addr),
        .imem         (imem_bus.master),
        .PC           (PC),
        .Instruction  (Instruction)
`ifdef IF_STALL_CNT_EN
        ,
        .Stall_Count  (Stall_Count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                              input logic [31:0] e_pc, input logic [31:0] e_ins);
        check_eq({tag, ".req"},  {31'd0, imem_bus.imem_req}, {31'd0, e_req});
        check_eq({tag, ".addr"}, imem_bus.imem_addr, e_addr);
        check_eq({tag, ".pc"},   PC, e_pc);
        check_eq({tag, ".ins"},  Instruction, e_ins);
    endtask

    // Called right after a falling edge: drive this cycle's inputs, check the
    // combinational outputs, then advance past the rising edge.
    task automatic cyc(input string tag, input logic rdy, input logic frz, input logic br,
                       input logic [31:0] ba, input logic e_req, input logic [31:0] e_addr,
                       input logic [31:0] e_pc, input logic [31:0] e_ins);
        ready_en     = rdy;
        freeze       = frz;
        Branch_taken = br;
        Branch_Addr  = ba;
        #1;
        check_outs(tag, e_req, e_addr, e_pc, e_ins);
        @(negedge clk);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b1;
        freeze       = 1'b0;
        Branch_taken = 1'b0;
        Branch_Addr  = 32'h0;
        ready_en     = 1'b1;

        #3;
        check_outs("reset", 1'b0, 32'h0, 32'h4, 32'h0);
`ifdef IF_STALL_CNT_EN
        check_eq("cnt_reset", Stall_Count, 32'h0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait sequential fetch
        cyc("f0",     1, 0, 0, 32'h0,   1, 32'h0, 32'h4, ~32'h0);
        cyc("f4",     1, 0, 0, 32'h0,   1, 32'h4, 32'h8, ~32'h4);
        // Two wait states on 0x8
        cyc("wait1",  0, 0, 0, 32'h0,   1, 32'h8, 32'hC, 32'h0);
        cyc("wait2",  0, 0, 0, 32'h0,   1, 32'h8, 32'hC, 32'h0);
        cyc("f8",     1, 0, 0, 32'h0,   1, 32'h8, 32'hC, ~32'h8);
        // Redirect while 0xC is in flight; second redirect wins, offset bits masked
        cyc("br_pend",  0, 0, 1, 32'h0F0, 1, 32'hC, 32'h10, 32'h0);
        cyc("br_again", 0, 0, 1, 32'h103, 1, 32'hC, 32'h10, 32'h0);
        cyc("drop",     1, 0, 0, 32'h0,   1, 32'hC, 32'h10, 32'h0);
`ifdef IF_STALL_CNT_EN
        #1;
        check_eq("cnt_five", Stall_Count, 32'd5);
`endif
        cyc("tgt100", 1, 0, 0, 32'h0,   1, 32'h100, 32'h104, ~32'h100);
        cyc("f104",   1, 0, 0, 32'h0,   1, 32'h104, 32'h108, ~32'h104);
        // Freeze when 0x108 returns: word shown for four cycles, no request
        cyc("frz_cap",  1, 1, 0, 32'h0, 1, 32'h108, 32'h10C, ~32'h108);
        cyc("hold1",    1, 1, 0, 32'h0, 0, 32'h108, 32'h10C, ~32'h108);
        cyc("hold2",    1, 1, 0, 32'h0, 0, 32'h108, 32'h10C, ~32'h108);
        cyc("hold_rel", 1, 0, 0, 32'h0, 0, 32'h108, 32'h10C, ~32'h108);
        cyc("f10c",     1, 1, 0, 32'h0, 1, 32'h10C, 32'h110, ~32'h10C);
        // Branch beats freeze in S_HOLD
        cyc("hold_br",  1, 1, 1, 32'h200, 0, 32'h10C, 32'h110, ~32'h10C);
        cyc("f200",     1, 0, 0, 32'h0,   1, 32'h200, 32'h204, ~32'h200);
        // Branch with ready in S_FETCH, then PC wrap
        cyc("br_rdy",   1, 0, 1, 32'hFFFF_FFFC, 1, 32'h204, 32'h208, ~32'h204);
        cyc("wrap",     1, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'h0, 32'h3);
        cyc("f0b",      1, 0, 0, 32'h0, 1, 32'h0, 32'h4, ~32'h0);
        // Freeze with no ready: nothing changes
        cyc("frz_nordy", 0, 1, 0, 32'h0, 1, 32'h4, 32'h8, 32'h0);
        cyc("frz_nordy2", 0, 0, 0, 32'h0, 1, 32'h4, 32'h8, 32'h0);

        // Asynchronous reset between clock edges
        ready_en = 1'b0;
        freeze   = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_outs("async_rst", 1'b0, 32'h0, 32'h4, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc("post_rst", 0, 0, 0, 32'h0, 1, 32'h0, 32'h4, 32'h0);

`ifdef IF_STALL_CNT_EN
        force dut.r_stall_count = 32'hFFFF_FFFD;
        #1;
        release dut.r_stall_count;
        repeat (4) @(negedge clk);
        #1;
        check_eq("cnt_sat", Stall_Count, 32'hFFFF_FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
